// File: rtl/wb_pwm_capture_pkg.sv
// Shared definitions for the Wishbone PWM capture block: register map,
// STATUS bit layout and the per-channel capture FSM encoding.
package wb_pwm_capture_pkg;

   localparam int REG_CTRL      = 0;
   localparam int REG_STATUS    = 1;
   localparam int REG_HIGH_BASE = 2;
   localparam int REG_STRIDE    = 2;

   localparam int STAT_VALID = 0;
   localparam int STAT_TMO   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_TMO  = 2'd3
   } cap_state_e;

endpackage

// File: rtl/wb_pwm_capture_ch.sv
// One PWM capture channel: input synchronizer, edge detector, measurement FSM
// and the published HIGH/PERIOD pair with single-cycle valid/timeout pulses.
module pwm_capture_ch
   import wb_pwm_capture_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high,
   output logic [CNT_W-1:0] period,
   output logic             set_valid,
   output logic             set_tmo
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync_p0, sync_p1, dly_p2;
   logic             rise, fall;
   cap_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] high_tmp, high_tmp_nxt;
   logic [CNT_W-1:0] high_nxt, period_nxt;

   // Stages p0/p1: metastability synchronizer; p2: previous level for edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         dly_p2  <= 1'b0;
      end else begin
         sync_p0 <= pwm_in;
         sync_p1 <= sync_p0;
         dly_p2  <= sync_p1;
      end
   end

   assign rise = sync_p1 & ~dly_p2;
   assign fall = ~sync_p1 & dly_p2;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      high_tmp_nxt = high_tmp;
      high_nxt     = high;
      period_nxt   = period;
      set_valid    = 1'b0;
      set_tmo      = 1'b0;
      if (!ena) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_IDLE, ST_TMO: begin
               if (rise) begin
                  state_nxt = ST_HIGH;
                  cnt_nxt   = CNT_ONE;
               end
            end
            ST_HIGH: begin
               if (cnt == CNT_MAX) begin
                  state_nxt = ST_TMO;
                  set_tmo   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
                  if (fall) begin
                     high_tmp_nxt = cnt;
                     state_nxt    = ST_LOW;
                  end
               end
            end
            ST_LOW: begin
               // A rise coinciding with saturation still publishes the full count
               if (rise) begin
                  high_nxt   = high_tmp;
                  period_nxt = cnt;
                  set_valid  = 1'b1;
                  cnt_nxt    = CNT_ONE;
                  state_nxt  = ST_HIGH;
               end else if (cnt == CNT_MAX) begin
                  state_nxt = ST_TMO;
                  set_tmo   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         high_tmp <= '0;
         high     <= '0;
         period   <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         high_tmp <= high_tmp_nxt;
         high     <= high_nxt;
         period   <= period_nxt;
      end
   end

endmodule

// File: rtl/wb_pwm_capture.sv
// Wishbone slave wrapper around CHANNELS PWM capture channels: bus handshake,
// CTRL/STATUS registers with W1C flags, and the registered read mux.
module wb_pwm_capture
   import wb_pwm_capture_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_stb_i,
   input  logic                wb_cyc_i,
   output logic                wb_ack_o,
   input  logic                wb_we_i,
   input  logic [31:0]         wb_adr_i,
   input  logic [3:0]          wb_sel_i,
   input  logic [31:0]         wb_dat_i,
   output logic [31:0]         wb_dat_o,
   input  logic [CHANNELS-1:0] pwm_in
);

   logic                ack;
   logic                access, wr;
   logic [3:0]          idx;
   logic                ena;
   logic [CHANNELS-1:0] valid, tmo;
   logic [CHANNELS-1:0] set_valid, set_tmo;
   logic [CHANNELS-1:0] w1c_valid, w1c_tmo;
   logic [CNT_W-1:0]    high_arr   [CHANNELS];
   logic [CNT_W-1:0]    period_arr [CHANNELS];
   logic [31:0]         rdata;
   logic                unused_bits;

   assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0]};

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pwm_capture_ch #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .rst       (rst),
         .ena       (ena),
         .pwm_in    (pwm_in[g]),
         .high      (high_arr[g]),
         .period    (period_arr[g]),
         .set_valid (set_valid[g]),
         .set_tmo   (set_tmo[g])
      );
   end

   assign idx      = wb_adr_i[5:2];
   assign access   = wb_stb_i & wb_cyc_i & ~ack;
   assign wr       = access & wb_we_i;
   assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;

   assign w1c_valid = (wr && idx == 4'(REG_STATUS)) ? wb_dat_i[STAT_VALID +: CHANNELS] : '0;
   assign w1c_tmo   = (wr && idx == 4'(REG_STATUS)) ? wb_dat_i[STAT_TMO +: CHANNELS]   : '0;

   always_comb begin
      rdata = '0;
      if (idx == 4'(REG_CTRL)) begin
         rdata[0] = ena;
      end else if (idx == 4'(REG_STATUS)) begin
         rdata[STAT_VALID +: CHANNELS] = valid;
         rdata[STAT_TMO +: CHANNELS]   = tmo;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (idx == 4'(REG_HIGH_BASE + REG_STRIDE * i))
               rdata = 32'(high_arr[i]);
            if (idx == 4'(REG_HIGH_BASE + REG_STRIDE * i + 1))
               rdata = 32'(period_arr[i]);
         end
      end
   end

   // Hardware set beats a simultaneous W1C; timeout invalidates the channel
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack      <= 1'b0;
         ena      <= 1'b0;
         valid    <= '0;
         tmo      <= '0;
         wb_dat_o <= '0;
      end else begin
         ack   <= wb_stb_i & wb_cyc_i & ~ack;
         valid <= ((valid & ~w1c_valid) | set_valid) & ~set_tmo;
         tmo   <= (tmo & ~w1c_tmo) | set_tmo;
         if (wr && idx == 4'(REG_CTRL))
            ena <= wb_dat_i[0];
         if (access)
            wb_dat_o <= wb_we_i ? 32'h0 : rdata;
      end
   end

endmodule

// File: tb/tb_wb_pwm_capture.sv
// Directed bench for wb_pwm_capture: table-driven register vectors plus
// hand-written PWM sequences for timeout, enable, reset and bus corner cases.
module tb_wb_pwm_capture;

   localparam int CH = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stb = 1'b0;
   logic          cyc = 1'b0;
   logic          we  = 1'b0;
   logic [31:0]   adr = '0;
   logic [3:0]    sel = 4'hF;
   logic [31:0]   dat_i = '0;
   logic [31:0]   dat_o;
   logic          ack;
   logic [CH-1:0] pwm_in;

   int hi  [CH] = '{default: 1};
   int lo  [CH] = '{default: 1};
   bit run [CH] = '{default: 1'b0};

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          w;
      int          idx;
      logic [31:0] d;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t        tbl [12];
   logic [31:0] rd;
   int          lat;

   always #5 clk = ~clk;

   wb_pwm_capture #(.CHANNELS(CH), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wb_stb_i (stb),
      .wb_cyc_i (cyc),
      .wb_ack_o (ack),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_sel_i (sel),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .pwm_in   (pwm_in)
   );

   // Per-channel waveform source: hi[g] cycles high, lo[g] cycles low while run[g]
   for (genvar g = 0; g < CH; g++) begin : g_pwm
      logic pw;
      assign pwm_in[g] = pw;
      initial begin
         pw = 1'b0;
         forever begin
            if (run[g]) begin
               pw = 1'b1;
               repeat (hi[g]) @(negedge clk);
               pw = 1'b0;
               repeat (lo[g]) @(negedge clk);
            end else begin
               pw = 1'b0;
               @(negedge clk);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation still running after 60000 cycles, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus(input bit w, input int idx, input logic [31:0] wd,
                      output logic [31:0] rdat, output int cycles);
      bit got;
      got    = 1'b0;
      cycles = 0;
      @(negedge clk);
      stb   = 1'b1;
      cyc   = 1'b1;
      we    = w;
      adr   = 32'(idx) << 2;
      dat_i = wd;
      while (!got && cycles < 5) begin
         @(posedge clk);
         #1;
         cycles++;
         got = ack;
      end
      rdat = dat_o;
      stb  = 1'b0;
      cyc  = 1'b0;
      we   = 1'b0;
      @(posedge clk);
   endtask

   task automatic rd_chk(input string name, input int idx, input logic [31:0] exp);
      logic [31:0] d;
      int          c;
      bus(1'b0, idx, 32'h0, d, c);
      chk({name, " ack latency"}, 32'(c), 32'd1);
      chk(name, d, exp);
   endtask

   task automatic wr(input int idx, input logic [31:0] d);
      logic [31:0] dd;
      int          c;
      bus(1'b1, idx, d, dd, c);
      chk("write ack latency", 32'(c), 32'd1);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 0,  32'h0,        32'h0, "ctrl after reset"};
      tbl[1]  = '{1'b0, 1,  32'h0,        32'h0, "status after reset"};
      tbl[2]  = '{1'b0, 2,  32'h0,        32'h0, "high0 after reset"};
      tbl[3]  = '{1'b0, 9,  32'h0,        32'h0, "period3 after reset"};
      tbl[4]  = '{1'b1, 0,  32'hFFFFFFFF, 32'h0, "ctrl write"};
      tbl[5]  = '{1'b0, 0,  32'h0,        32'h1, "ctrl only bit0"};
      tbl[6]  = '{1'b1, 1,  32'hFFFFFFFF, 32'h0, "status w1c"};
      tbl[7]  = '{1'b0, 1,  32'h0,        32'h0, "status idle"};
      tbl[8]  = '{1'b0, 12, 32'h0,        32'h0, "unmapped index 12"};
      tbl[9]  = '{1'b1, 15, 32'h12345678, 32'h0, "unmapped write 15"};
      tbl[10] = '{1'b0, 0,  32'h0,        32'h1, "ctrl after unmapped write"};
      tbl[11] = '{1'b0, 1,  32'h0,        32'h0, "status after unmapped write"};

      repeat (3) @(negedge clk);
      chk("ack in reset", 32'(ack), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         bus(tbl[i].w, tbl[i].idx, tbl[i].d, rd, lat);
         chk({tbl[i].name, " ack latency"}, 32'(lat), 32'd1);
         if (!tbl[i].w)
            chk(tbl[i].name, rd, tbl[i].exp);
      end

      // Channel 0: 300 high / 700 low
      hi[0] = 300; lo[0] = 700; run[0] = 1'b1;
      repeat (3050) @(negedge clk);
      rd_chk("high0 300/700", 2, 32'd300);
      rd_chk("period0 300/700", 3, 32'd1000);
      rd_chk("status ch0 valid", 1, 32'h001);
      wr(1, 32'h001);
      rd_chk("status after w1c", 1, 32'h000);
      repeat (1000) @(negedge clk);
      rd_chk("status valid again", 1, 32'h001);

      // Disable mid-high, then re-enable and require a full rise-fall-rise
      @(posedge pwm_in[0]);
      repeat (100) @(negedge clk);
      wr(0, 32'h0);
      run[0] = 1'b0;
      repeat (1500) @(negedge clk);
      rd_chk("high0 held while disabled", 2, 32'd300);
      rd_chk("period0 held while disabled", 3, 32'd1000);
      rd_chk("status held while disabled", 1, 32'h001);
      wr(1, 32'h001);
      hi[0] = 200; lo[0] = 400;
      wr(0, 32'h1);
      run[0] = 1'b1;
      @(posedge pwm_in[0]);
      repeat (400) @(negedge clk);
      rd_chk("status no update after first rise-fall", 1, 32'h000);
      rd_chk("high0 no update after first rise-fall", 2, 32'd300);
      @(posedge pwm_in[0]);
      repeat (10) @(negedge clk);
      rd_chk("high0 200/400", 2, 32'd200);
      rd_chk("period0 200/400", 3, 32'd600);
      rd_chk("status after re-enable", 1, 32'h001);
      wr(0, 32'h0);
      run[0] = 1'b0;
      wr(1, 32'h001);
      repeat (700) @(negedge clk);

      // Channel 1: one valid 40/60 period, then a 1100-cycle low causes timeout
      wr(0, 32'h1);
      hi[1] = 40; lo[1] = 60; run[1] = 1'b1;
      repeat (350) @(negedge clk);
      rd_chk("high1 40/60", 4, 32'd40);
      rd_chk("period1 40/60", 5, 32'd100);
      rd_chk("status ch1 valid", 1, 32'h002);
      @(posedge pwm_in[1]);
      lo[1] = 1100;
      @(negedge pwm_in[1]);
      hi[1] = 50; lo[1] = 100;
      repeat (1050) @(negedge clk);
      rd_chk("status ch1 timeout", 1, 32'h200);
      rd_chk("period1 kept on timeout", 5, 32'd100);
      rd_chk("high1 kept on timeout", 4, 32'd40);
      @(posedge pwm_in[1]);
      @(posedge pwm_in[1]);
      repeat (10) @(negedge clk);
      rd_chk("high1 after timeout", 4, 32'd50);
      rd_chk("period1 after timeout", 5, 32'd150);
      rd_chk("status tmo sticky", 1, 32'h202);
      wr(1, 32'h200);
      rd_chk("status tmo w1c", 1, 32'h002);
      wr(0, 32'h0);
      run[1] = 1'b0;

      // Bus corners: ack drops with stb, held stb acks every other cycle
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h0;
      @(posedge clk);
      #1 chk("ack on second strobe cycle", 32'(ack), 32'd1);
      @(negedge clk);
      stb = 1'b0;
      #1 chk("ack drops with stb", 32'(ack), 32'd0);
      cyc = 1'b0;
      @(negedge clk);
      stb = 1'b1; cyc = 1'b1; adr = 32'h4;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 chk("back-to-back ack pattern", 32'(ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      stb = 1'b0; cyc = 1'b0;
      @(posedge clk);

      // Channel 2: reset mid-low discards the partial cycle
      wr(0, 32'h1);
      hi[2] = 100; lo[2] = 200; run[2] = 1'b1;
      @(negedge pwm_in[2]);
      repeat (50) @(negedge clk);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h4;
      @(posedge clk);
      #1 chk("ack before reset", 32'(ack), 32'd1);
      rst = 1'b0;
      #1 chk("ack cleared by async reset", 32'(ack), 32'd0);
      stb = 1'b0; cyc = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rd_chk("ctrl after reset", 0, 32'h0);
      rd_chk("status after reset", 1, 32'h0);
      rd_chk("high0 after reset", 2, 32'h0);
      rd_chk("period0 after reset", 3, 32'h0);
      rd_chk("period1 after reset", 5, 32'h0);
      rd_chk("period2 after reset", 7, 32'h0);
      wr(0, 32'h1);
      @(posedge pwm_in[2]);
      repeat (10) @(negedge clk);
      rd_chk("status no publish on first rise", 1, 32'h000);
      rd_chk("period2 no publish on first rise", 7, 32'h0);
      @(posedge pwm_in[2]);
      repeat (10) @(negedge clk);
      rd_chk("high2 complete cycle", 6, 32'd100);
      rd_chk("period2 complete cycle", 7, 32'd300);
      rd_chk("status ch2 valid", 1, 32'h004);
      run[2] = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
